// File: rtl/l1_mem_pkg.sv
// ---------------------------------------------------------------------------
// l1_mem_pkg
// Shared constants and types for the L1 line responder:
//   - FSM state encodings (ST_*)
//   - line / word / beat / offset widths
//   - operating modes of the line beat shifter
// ---------------------------------------------------------------------------
package l1_mem_pkg;

    localparam int LINE_BITS   = 256;
    localparam int WORD_BITS   = 32;
    localparam int BEAT_BITS   = 3;
    localparam int OFFSET_BITS = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_RD_TAIL = 3'd2;
    localparam logic [2:0] ST_WR      = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_COOL    = 3'd5;

    // HOLD: keep buffer; LOAD: latch a writeback line and present word 0;
    // SHIFT_OUT: present the next write word; SHIFT_IN: capture a read word.
    typedef enum logic [1:0] {
        SHF_HOLD      = 2'd0,
        SHF_LOAD      = 2'd1,
        SHF_SHIFT_OUT = 2'd2,
        SHF_SHIFT_IN  = 2'd3
    } shf_mode_e;

endpackage

// File: rtl/line_beat_shifter.sv
// ---------------------------------------------------------------------------
// line_beat_shifter
// 256-bit line buffer plus beat counter used by l1_line_responder.
//   sys_clk, rst        : clock, synchronous active-high reset
//   mode                : HOLD / LOAD / SHIFT_OUT / SHIFT_IN
//   beat_clr, beat_inc  : beat counter control (clear wins)
//   line_in             : writeback line, latched on LOAD
//   word_in             : RAM read word, shifted in on SHIFT_IN
//   beat                : current beat number
//   word_out            : registered write word (word k during write beat k)
//   line_shifted_in     : buffer contents after shifting word_in in
// Words travel LSB-first: word 0 of a line is bits [31:0].
// ---------------------------------------------------------------------------
module line_beat_shifter
    import l1_mem_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  rst,
    input  shf_mode_e             mode,
    input  logic                  beat_clr,
    input  logic                  beat_inc,
    input  logic [LINE_BITS-1:0]  line_in,
    input  logic [WORD_BITS-1:0]  word_in,
    output logic [BEAT_BITS-1:0]  beat,
    output logic [WORD_BITS-1:0]  word_out,
    output logic [LINE_BITS-1:0]  line_shifted_in
);

    logic [LINE_BITS-1:0] line_r;
    logic [WORD_BITS-1:0] word_r;
    logic [BEAT_BITS-1:0] beat_r;

    // Read words enter at the top so that after 8 captures word 0 sits at [31:0].
    assign line_shifted_in = {word_in, line_r[LINE_BITS-1:WORD_BITS]};
    assign beat            = beat_r;
    assign word_out        = word_r;

    // Line buffer and outgoing write word.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            line_r <= {LINE_BITS{1'b0}};
            word_r <= {WORD_BITS{1'b0}};
        end else begin
            case (mode)
                SHF_LOAD: begin
                    // Word 0 goes straight to the output; the rest queue behind it.
                    word_r <= line_in[WORD_BITS-1:0];
                    line_r <= {{WORD_BITS{1'b0}}, line_in[LINE_BITS-1:WORD_BITS]};
                end
                SHF_SHIFT_OUT: begin
                    word_r <= line_r[WORD_BITS-1:0];
                    line_r <= {{WORD_BITS{1'b0}}, line_r[LINE_BITS-1:WORD_BITS]};
                end
                SHF_SHIFT_IN: begin
                    line_r <= line_shifted_in;
                end
                SHF_HOLD: begin
                    line_r <= line_r;
                end
                default: begin
                    line_r <= line_r;
                end
            endcase
        end
    end

    // Beat counter.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            beat_r <= {BEAT_BITS{1'b0}};
        end else if (beat_clr) begin
            beat_r <= {BEAT_BITS{1'b0}};
        end else if (beat_inc) begin
            beat_r <= beat_r + 3'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

endmodule

// File: rtl/l1_line_responder.sv
// ---------------------------------------------------------------------------
// l1_line_responder
// Memory-side responder for the L1 refill/writeback handshake. Each line
// request becomes an 8-beat burst on a 32-bit synchronous RAM followed by a
// one-cycle done pulse.
//   sys_clk, rst          : clock, synchronous active-high reset
//   l1_mmu_req_read/write : level requests, write has priority
//   l1_mmu_req_addr       : byte address, line index in [LINE_AW+4:5]
//   l1_mmu_write_data     : writeback line (word k = bits [32k+31:32k])
//   mmu_l1_read_done      : one-cycle pulse, refill data valid
//   mmu_l1_write_done     : one-cycle pulse, writeback committed
//   mmu_l1_read_data      : last refilled line, held until the next read
//   ram_addr/ram_din/ram_we/ram_dout : word RAM port (dout one cycle after addr)
// Sequence: IDLE -> RD x8 -> RD_TAIL -> DONE -> COOL -> IDLE (read)
//           IDLE -> WR x8 -> DONE -> COOL -> IDLE            (write)
// ---------------------------------------------------------------------------
module l1_line_responder
    import l1_mem_pkg::*;
#(
    parameter int LINE_AW = 12,
    parameter int WORDS   = 8
)(
    input  logic                          sys_clk,
    input  logic                          rst,
    input  logic                          l1_mmu_req_read,
    input  logic                          l1_mmu_req_write,
    input  logic [31:0]                   l1_mmu_req_addr,
    input  logic [LINE_BITS-1:0]          l1_mmu_write_data,
    output logic                          mmu_l1_read_done,
    output logic                          mmu_l1_write_done,
    output logic [LINE_BITS-1:0]          mmu_l1_read_data,
    output logic [LINE_AW+BEAT_BITS-1:0]  ram_addr,
    output logic [WORD_BITS-1:0]          ram_din,
    output logic                          ram_we,
    input  logic [WORD_BITS-1:0]          ram_dout
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WORDS - 1);

    logic [2:0]                     state_r;
    logic [2:0]                     state_s;
    logic [LINE_AW-1:0]             idx_r;
    logic [LINE_AW-1:0]             idx_s;
    logic [LINE_AW-1:0]             req_idx_s;
    logic                           read_done_r;
    logic                           read_done_s;
    logic                           write_done_r;
    logic                           write_done_s;
    logic [LINE_BITS-1:0]           read_data_r;
    logic                           load_rdata_s;
    logic [LINE_AW+BEAT_BITS-1:0]   ram_addr_r;
    logic [LINE_AW+BEAT_BITS-1:0]   ram_addr_s;
    logic                           ram_we_r;
    logic                           ram_we_s;
    shf_mode_e                      mode_s;
    logic                           beat_clr_s;
    logic                           beat_inc_s;
    logic [BEAT_BITS-1:0]           beat_s;
    logic [LINE_BITS-1:0]           line_shifted_in_s;
    logic                           unused_addr_bits_s;

    assign req_idx_s          = l1_mmu_req_addr[LINE_AW+OFFSET_BITS-1:OFFSET_BITS];
    assign unused_addr_bits_s = ^{l1_mmu_req_addr[31:LINE_AW+OFFSET_BITS],
                                  l1_mmu_req_addr[OFFSET_BITS-1:0]};

    line_beat_shifter u_shifter (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .mode            (mode_s),
        .beat_clr        (beat_clr_s),
        .beat_inc        (beat_inc_s),
        .line_in         (l1_mmu_write_data),
        .word_in         (ram_dout),
        .beat            (beat_s),
        .word_out        (ram_din),
        .line_shifted_in (line_shifted_in_s)
    );

    // Next-state and next-output decode. RAM address/we are computed one
    // cycle ahead so they leave the block straight from flops.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        ram_addr_s   = ram_addr_r;
        ram_we_s     = 1'b0;
        mode_s       = SHF_HOLD;
        beat_clr_s   = 1'b0;
        beat_inc_s   = 1'b0;
        load_rdata_s = 1'b0;
        read_done_s  = 1'b0;
        write_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (l1_mmu_req_write) begin
                    state_s    = ST_WR;
                    idx_s      = req_idx_s;
                    ram_addr_s = {req_idx_s, 3'd0};
                    ram_we_s   = 1'b1;
                    mode_s     = SHF_LOAD;
                    beat_clr_s = 1'b1;
                end else if (l1_mmu_req_read) begin
                    state_s    = ST_RD;
                    idx_s      = req_idx_s;
                    ram_addr_s = {req_idx_s, 3'd0};
                    beat_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                // Data for beat b arrives during beat b+1, so beat 0 captures nothing.
                if (beat_s != 3'd0) begin
                    mode_s = SHF_SHIFT_IN;
                end else begin
                    mode_s = SHF_HOLD;
                end
                if (beat_s == LAST_BEAT) begin
                    state_s = ST_RD_TAIL;
                end else begin
                    beat_inc_s = 1'b1;
                    ram_addr_s = {idx_r, beat_s + 3'd1};
                end
            end
            ST_RD_TAIL: begin
                // Capture the last word and publish the completed line together.
                mode_s       = SHF_SHIFT_IN;
                load_rdata_s = 1'b1;
                read_done_s  = 1'b1;
                state_s      = ST_DONE;
            end
            ST_WR: begin
                if (beat_s == LAST_BEAT) begin
                    state_s      = ST_DONE;
                    write_done_s = 1'b1;
                end else begin
                    ram_we_s   = 1'b1;
                    mode_s     = SHF_SHIFT_OUT;
                    beat_inc_s = 1'b1;
                    ram_addr_s = {idx_r, beat_s + 3'd1};
                end
            end
            ST_DONE: begin
                state_s = ST_COOL;
            end
            ST_COOL: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched line index and all registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {LINE_AW{1'b0}};
            ram_addr_r   <= {(LINE_AW+BEAT_BITS){1'b0}};
            ram_we_r     <= 1'b0;
            read_done_r  <= 1'b0;
            write_done_r <= 1'b0;
            read_data_r  <= {LINE_BITS{1'b0}};
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            ram_addr_r   <= ram_addr_s;
            ram_we_r     <= ram_we_s;
            read_done_r  <= read_done_s;
            write_done_r <= write_done_s;
            if (load_rdata_s) begin
                read_data_r <= line_shifted_in_s;
            end else begin
                read_data_r <= read_data_r;
            end
        end
    end

    assign mmu_l1_read_done  = read_done_r;
    assign mmu_l1_write_done = write_done_r;
    assign mmu_l1_read_data  = read_data_r;
    assign ram_addr          = ram_addr_r;
    assign ram_we            = ram_we_r;

endmodule

// File: tb/tb_l1_line_responder.sv
// ---------------------------------------------------------------------------
// tb_l1_line_responder
// Table of line operations plus hand-written corner sequences. Expected done
// pulses (kind, cycle, line) and expected RAM write beats are queued when a
// request is driven and compared by a monitor when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_l1_line_responder;
    import l1_mem_pkg::*;

    localparam int LINE_AW = 12;
    localparam int RAM_AW  = LINE_AW + 3;
    localparam int RAM_N   = 1 << RAM_AW;

    logic                 sys_clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 req_read = 1'b0;
    logic                 req_write = 1'b0;
    logic [31:0]          req_addr = 32'd0;
    logic [255:0]         wdata = 256'd0;
    logic                 read_done;
    logic                 write_done;
    logic [255:0]         read_data;
    logic [RAM_AW-1:0]    ram_addr;
    logic [31:0]          ram_din;
    logic                 ram_we;
    logic [31:0]          ram_dout;

    always #5 sys_clk = ~sys_clk;

    l1_line_responder #(.LINE_AW(LINE_AW), .WORDS(8)) dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .l1_mmu_req_read   (req_read),
        .l1_mmu_req_write  (req_write),
        .l1_mmu_req_addr   (req_addr),
        .l1_mmu_write_data (wdata),
        .mmu_l1_read_done  (read_done),
        .mmu_l1_write_done (write_done),
        .mmu_l1_read_data  (read_data),
        .ram_addr          (ram_addr),
        .ram_din           (ram_din),
        .ram_we            (ram_we),
        .ram_dout          (ram_dout)
    );

    typedef struct {
        logic         is_wr;
        int           cyc;
        logic [255:0] line;
    } exp_t;

    typedef struct {
        logic [RAM_AW-1:0] addr;
        logic [31:0]       din;
    } beat_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] base;
        int          lat;
    } vec_t;

    exp_t  sb[$];
    beat_t wq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    done_seen = 0;
    logic  mon_en = 1'b0;
    logic  preload = 1'b1;
    logic  prev_done = 1'b0;
    exp_t  m_e;
    beat_t m_b;

    logic [31:0] ram_mem [0:RAM_N-1];
    logic [31:0] exp_mem [0:RAM_N-1];

    function automatic logic [31:0] init_word(input int i);
        if (i >= 24 && i < 32) return 32'h1000_0000 + 32'(i - 24);
        return {16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [255:0] model_line(input logic [LINE_AW-1:0] idx);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = exp_mem[{idx, 3'(k)}];
        return l;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous word RAM: dout is valid one cycle after the address.
    always @(posedge sys_clk) begin
        if (preload) begin
            for (int i = 0; i < RAM_N; i++) ram_mem[i] <= init_word(i);
        end else if (ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_mem[ram_addr];
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Output monitor: pops expected done pulses and write beats.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (read_done || write_done) begin
                done_seen++;
                chk("done_adjacent", {255'd0, prev_done}, 256'd0);
                chk("done_both", {255'd0, read_done & write_done}, 256'd0);
                if (sb.size() == 0) begin
                    chk("done_unexpected", 256'd1, 256'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("done_kind", {254'd0, write_done, read_done}, {254'd0, m_e.is_wr, ~m_e.is_wr});
                    chk("done_cycle", 256'(cyc), 256'(m_e.cyc));
                    if (!m_e.is_wr) chk("read_data", read_data, m_e.line);
                end
            end
            if (ram_we) begin
                if (wq.size() == 0) begin
                    chk("we_unexpected", 256'd1, 256'd0);
                end else begin
                    m_b = wq.pop_front();
                    chk("we_addr", 256'(ram_addr), 256'(m_b.addr));
                    chk("we_din", 256'(ram_din), 256'(m_b.din));
                end
            end
        end
        prev_done = read_done | write_done;
    end

    // Queue expectations for one request and drive it (called in an IDLE cycle).
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] base, input int lat);
        logic [LINE_AW-1:0] idx;
        logic [255:0]       line;
        exp_t               e;
        beat_t              b;
        int                 c0;
        idx  = addr[LINE_AW+4:5];
        c0   = cyc;
        line = ~256'd0;
        if (wr) begin
            for (int k = 0; k < 8; k++) begin
                line[32*k +: 32] = base + 32'(k);
                b.addr = {idx, 3'(k)};
                b.din  = base + 32'(k);
                wq.push_back(b);
                exp_mem[{idx, 3'(k)}] = base + 32'(k);
            end
            e = '{1'b1, c0 + lat, line};
            sb.push_back(e);
        end
        if (rd) begin
            e = '{1'b0, wr ? c0 + lat + 12 : c0 + lat, model_line(idx)};
            sb.push_back(e);
        end
        req_write = wr;
        req_read  = rd;
        req_addr  = addr;
        wdata     = line;
    endtask

    task automatic wait_dones(input int n, input int budget);
        int target;
        int t;
        target = done_seen + n;
        t = 0;
        while (done_seen < target && t < budget) begin
            @(posedge sys_clk);
            t++;
        end
        if (done_seen < target) chk("done_timeout", 256'(done_seen), 256'(target));
    endtask

    // Drop requests in COOL and return in the following IDLE cycle.
    task automatic release_req();
        #1;
        req_read  = 1'b0;
        req_write = 1'b0;
        @(posedge sys_clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        logic [255:0] ln;
        vecs[0] = '{1'b0, 32'h0000_0060, 32'h0000_0000, 10};
        vecs[1] = '{1'b1, 32'h0000_0040, 32'hA0A0_0000, 9};
        vecs[2] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 10};
        vecs[3] = '{1'b1, 32'hFFFF_FFE0, 32'h5A5A_0000, 9};
        vecs[4] = '{1'b0, 32'hFFFF_FFE0, 32'h0000_0000, 10};
        vecs[5] = '{1'b0, 32'h0000_001F, 32'h0000_0000, 10};
        vecs[6] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFF8, 9};
        vecs[7] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 10};
        for (int i = 0; i < RAM_N; i++) exp_mem[i] = init_word(i);

        // Reset state.
        repeat (3) @(posedge sys_clk);
        #1 preload = 1'b0;
        @(negedge sys_clk);
        chk("rst_read_done", 256'(read_done), 256'd0);
        chk("rst_write_done", 256'(write_done), 256'd0);
        chk("rst_ram_we", 256'(ram_we), 256'd0);
        chk("rst_ram_addr", 256'(ram_addr), 256'd0);
        chk("rst_ram_din", 256'(ram_din), 256'd0);
        chk("rst_read_data", read_data, 256'd0);
        @(posedge sys_clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(posedge sys_clk);
        #1;

        // Table of single operations.
        for (int v = 0; v < 8; v++) begin
            issue(vecs[v].wr, ~vecs[v].wr, vecs[v].addr, vecs[v].base, vecs[v].lat);
            wait_dones(1, 30);
            release_req();
        end

        // Line 3 still holds its preloaded contents.
        ln = model_line(12'h003);
        chk("line3_word0", 256'(ln[31:0]), 256'h1000_0000);
        chk("line3_word7", 256'(ln[255:224]), 256'h1000_0007);

        // Read and write together: write first, held read accepted after COOL.
        issue(1'b1, 1'b1, 32'h0000_0020, 32'h3C3C_0000, 9);
        wait_dones(1, 30);
        #1 req_write = 1'b0;
        wait_dones(1, 30);
        release_req();

        // Address changes at read beat 3; burst stays on the latched line.
        issue(1'b0, 1'b1, 32'h0000_0060, 32'h0, 10);
        repeat (4) @(posedge sys_clk);
        #1;
        chk("beat3_addr", 256'(ram_addr), 256'({12'h003, 3'd3}));
        req_addr = 32'hFFFF_FFE0;
        wait_dones(1, 30);
        release_req();

        // Reset while write beat 3 is on the bus: beat 4 never happens.
        for (int k = 0; k < 4; k++) begin
            m_b.addr = {12'h005, 3'(k)};
            m_b.din  = 32'h7777_0000 + 32'(k);
            wq.push_back(m_b);
            exp_mem[{12'h005, 3'(k)}] = 32'h7777_0000 + 32'(k);
        end
        for (int k = 0; k < 8; k++) wdata[32*k +: 32] = 32'h7777_0000 + 32'(k);
        req_addr  = 32'h0000_00A0;
        req_write = 1'b1;
        repeat (4) @(posedge sys_clk);
        #1;
        rst       = 1'b1;
        req_write = 1'b0;
        @(posedge sys_clk);
        #1 rst = 1'b0;
        @(negedge sys_clk);
        chk("abort_ram_we", 256'(ram_we), 256'd0);
        chk("abort_done", 256'({read_done, write_done}), 256'd0);
        chk("abort_read_data", read_data, 256'd0);
        chk("abort_beats_left", 256'(wq.size()), 256'd0);
        @(posedge sys_clk);
        #1;
        issue(1'b0, 1'b1, 32'h0000_00A0, 32'h0, 10);
        wait_dones(1, 30);
        release_req();

        // Read held across three operations: pulses 12 cycles apart.
        for (int j = 0; j < 3; j++) begin
            m_e = '{1'b0, cyc + 10 + 12 * j, model_line(12'h003)};
            sb.push_back(m_e);
        end
        req_addr = 32'h0000_0060;
        req_read = 1'b1;
        wait_dones(3, 60);
        release_req();

        repeat (4) @(posedge sys_clk);
        chk("sb_empty", 256'(sb.size()), 256'd0);
        chk("wq_empty", 256'(wq.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
